// File: rtl/sisc_mem_arb_pkg.sv
// Shared types and constants for the SISC memory arbiter.
// Used by the arbiter top (sisc_mem_arb) and its winner-select sub-block (sisc_arb_pick).
package sisc_arb_pkg;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Grant owner encoding; also the encoding of the round-robin last-served pointer.
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  // Width of the latency down-counter; it covers MEM_LAT up to 15.
  localparam int LAT_W = 4;

endpackage

// File: rtl/sisc_mem_arb_if.sv
// Bus bundle between the SISC requesters (fetch and data paths), the arbiter
// and the memory macro.
// - The slave modport is the arbiter's view.
// - The master modport is the view of the requesters and memory around it.
interface sisc_mem_arb_if #(
  parameter int AW = 16,
  parameter int DW = 32
) ();

  // Instruction fetch requester.
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;

  // Data (LOD/STR) requester.
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;

  // Memory macro.
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_ack, if_rdata, dm_ack, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_ack, if_rdata, dm_ack, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/sisc_mem_arb_pick.sv
// Combinational winner select for the SISC memory arbiter.
// - Default: DM beats IF whenever both request.
// - SISC_ARB_RR_EN defined: on contention, the side that was not served last
//   wins. The last-served pointer itself lives in the parent.
module sisc_arb_pick
  import sisc_arb_pkg::*;
(
  input  logic if_req,
  input  logic dm_req,
`ifdef SISC_ARB_RR_EN
  input  logic last_own,
`endif
  output logic any_req,
  output logic win
);

  // Pick the owner of the next access from the pending requests.
  always_comb begin
    // NOTE: every output gets a default first so no path through the block
    // leaves it unassigned, which would otherwise infer a latch.
    any_req = if_req | dm_req;
    win     = OWN_IF;
`ifdef SISC_ARB_RR_EN
    if (if_req && dm_req) begin
      win = (last_own == OWN_IF) ? OWN_DM : OWN_IF;
    end else if (dm_req) begin
      win = OWN_DM;
    end
`else
    if (dm_req) begin
      win = OWN_DM;
    end
`endif
  end

endmodule

// File: rtl/sisc_mem_arb.sv
// Single-port memory arbiter for the SISC multicycle core.
// - Shares one memory between instruction fetch and data LOD/STR.
// - Each access is: grant in IDLE, MEM_LAT cycles in ACCESS, then a
//   one-cycle ack in DONE.
// - Optional macro SISC_ARB_RR_EN replaces fixed DM-over-IF priority with
//   two-way round-robin.
// - All outputs are registered.
module sisc_mem_arb
  import sisc_arb_pkg::*;
#(
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic           clk,
  input  logic           rst_f,
  sisc_mem_arb_if.slave  bus,
  output logic           busy,
  output logic           owner
);

  // Reject latencies the counter or the FSM cannot represent.
  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_lat_chk
    $error("sisc_mem_arb: MEM_LAT must be in 1..15");
  end

  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);

  state_t           state;
  logic [LAT_W-1:0] cnt;
  logic             any_req;
  logic             win;
  logic [AW-1:0]    addr_win;
  logic [DW-1:0]    wdata_win;

`ifdef SISC_ARB_RR_EN
  logic             last_own;
`endif

  sisc_arb_pick u_pick (
    .if_req  (bus.if_req),
    .dm_req  (bus.dm_req),
`ifdef SISC_ARB_RR_EN
    .last_own(last_own),
`endif
    .any_req (any_req),
    .win     (win)
  );

  // Steer address and write data from the requester that wins this cycle.
  // A fetch never writes, so its write data is forced to zero.
  assign addr_win  = (win == OWN_DM) ? bus.dm_addr  : bus.if_addr;
  assign wdata_win = (win == OWN_DM) ? bus.dm_wdata : '0;

  // Request / access / ack sequencer; every output is a flop of this block.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so that every
    // right-hand side sees the pre-edge values, regardless of statement order.
    if (!rst_f) begin
      state         <= IDLE;
      cnt           <= '0;
      busy          <= 1'b0;
      owner         <= OWN_IF;
      bus.if_ack    <= 1'b0;
      bus.if_rdata  <= '0;
      bus.dm_ack    <= 1'b0;
      bus.dm_rdata  <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
`ifdef SISC_ARB_RR_EN
      last_own      <= OWN_IF;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= (win == OWN_DM) & bus.dm_we;
            bus.mem_addr  <= addr_win;
            bus.mem_wdata <= wdata_win;
            owner         <= win;
            cnt           <= LAT_INIT;
            busy          <= 1'b1;
            state         <= ACCESS;
`ifdef SISC_ARB_RR_EN
            last_own      <= win;
`endif
          end
        end

        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            if (owner == OWN_IF) begin
              bus.if_rdata <= bus.mem_rdata;
              bus.if_ack   <= 1'b1;
            end else begin
              // A store returns no data; dm_rdata keeps the last load.
              if (!bus.mem_we) begin
                bus.dm_rdata <= bus.mem_rdata;
              end
              bus.dm_ack <= 1'b1;
            end
            bus.mem_en <= 1'b0;
            bus.mem_we <= 1'b0;
            state      <= DONE;
          end
        end

        DONE: begin
          bus.if_ack <= 1'b0;
          bus.dm_ack <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
